// File: rtl/lru_cache.sv
// Fully associative write-back / write-allocate cache with true-LRU replacement,
// one data word per line, sitting in front of a single-port synchronous RAM.
module lru_cache #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINES      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic                  ready,
    output logic                  valid,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    localparam int unsigned AW = $clog2(LINES);

    typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, RESP} stateType;

    stateType              state;
    logic                  lineValid [LINES];
    logic                  lineDirty [LINES];
    logic [ADDR_WIDTH-1:0] lineTag   [LINES];
    logic [DATA_WIDTH-1:0] lineData  [LINES];
    logic [AW-1:0]         lineAge   [LINES];

    logic [ADDR_WIDTH-1:0] reqAddress;
    logic [DATA_WIDTH-1:0] reqData;
    logic                  reqWren;
    logic [AW-1:0]         victimReg;

    logic                  accept;
    logic                  anyHit;
    logic [AW-1:0]         hitIdx;
    logic [AW-1:0]         victimSel;
    logic                  victimDirty;
    logic                  touchEn;
    logic [AW-1:0]         touchIdx;

    assign accept      = req && ready;
    assign victimDirty = lineValid[victimSel] && lineDirty[victimSel];

    // Tag match across all valid lines; at most one can match.
    always_comb begin
        anyHit = 1'b0;
        hitIdx = '0;
        for (int i = 0; i < int'(LINES); i++) begin
            if (lineValid[i] && lineTag[i] == address) begin
                anyHit = 1'b1;
                hitIdx = AW'(i);
            end
        end
    end

    // Lowest-index invalid line wins over the least recently used one.
    always_comb begin
        victimSel = '0;
        for (int i = 0; i < int'(LINES); i++) begin
            if (lineAge[i] == AW'(LINES - 1)) victimSel = AW'(i);
        end
        for (int i = int'(LINES) - 1; i >= 0; i--) begin
            if (!lineValid[i]) victimSel = AW'(i);
        end
    end

    always_comb begin
        touchEn  = 1'b0;
        touchIdx = victimReg;
        case (state)
            IDLE: begin
                if (accept && anyHit) begin
                    touchEn  = 1'b1;
                    touchIdx = hitIdx;
                end else if (accept && wren && !victimDirty) begin
                    touchEn  = 1'b1;
                    touchIdx = victimSel;
                end
            end
            WB:        touchEn = reqWren;
            FILL_WAIT: touchEn = 1'b1;
            default:   touchEn = 1'b0;
        endcase
    end

    // Ages stay a permutation: only lines younger than the touched one shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(LINES); i++) lineAge[i] <= AW'(i);
        end else if (touchEn) begin
            for (int i = 0; i < int'(LINES); i++) begin
                if (AW'(i) == touchIdx) lineAge[i] <= '0;
                else if (lineAge[i] < lineAge[touchIdx]) lineAge[i] <= lineAge[i] + AW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            valid       <= 1'b0;
            hit         <= 1'b0;
            q           <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            reqAddress  <= '0;
            reqData     <= '0;
            reqWren     <= 1'b0;
            victimReg   <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                lineValid[i] <= 1'b0;
                lineDirty[i] <= 1'b0;
                lineTag[i]   <= '0;
                lineData[i]  <= '0;
            end
        end else begin
            valid    <= 1'b0;
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqAddress <= address;
                        reqData    <= data;
                        reqWren    <= wren;
                        victimReg  <= victimSel;
                        ready      <= 1'b0;
                        if (anyHit) begin
                            if (wren) begin
                                lineData[hitIdx]  <= data;
                                lineDirty[hitIdx] <= 1'b1;
                                q                 <= data;
                            end else begin
                                q <= lineData[hitIdx];
                            end
                            hit   <= 1'b1;
                            valid <= 1'b1;
                            state <= RESP;
                        end else if (victimDirty) begin
                            mem_address <= lineTag[victimSel];
                            mem_data    <= lineData[victimSel];
                            mem_wren    <= 1'b1;
                            state       <= WB;
                        end else if (wren) begin
                            lineValid[victimSel] <= 1'b1;
                            lineDirty[victimSel] <= 1'b1;
                            lineTag[victimSel]   <= address;
                            lineData[victimSel]  <= data;
                            q                    <= data;
                            hit                  <= 1'b0;
                            valid                <= 1'b1;
                            state                <= RESP;
                        end else begin
                            mem_address <= address;
                            state       <= FILL_REQ;
                        end
                    end
                end
                WB: begin
                    if (reqWren) begin
                        lineValid[victimReg] <= 1'b1;
                        lineDirty[victimReg] <= 1'b1;
                        lineTag[victimReg]   <= reqAddress;
                        lineData[victimReg]  <= reqData;
                        q                    <= reqData;
                        hit                  <= 1'b0;
                        valid                <= 1'b1;
                        state                <= RESP;
                    end else begin
                        mem_address <= reqAddress;
                        state       <= FILL_REQ;
                    end
                end
                FILL_REQ: state <= FILL_WAIT;
                FILL_WAIT: begin
                    lineValid[victimReg] <= 1'b1;
                    lineDirty[victimReg] <= 1'b0;
                    lineTag[victimReg]   <= reqAddress;
                    lineData[victimReg]  <= mem_q;
                    q                    <= mem_q;
                    hit                  <= 1'b0;
                    valid                <= 1'b1;
                    state                <= RESP;
                end
                RESP: begin
                    hit   <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/lru_cache.md
# lru_cache

Parametrised, fully associative, write-back, write-allocate cache with true-LRU replacement, placed between a requester and a single-port synchronous backing RAM. Each line holds one data word. Misses are serviced from the backing RAM, and dirty victims are written back before reuse. Requests use a req/ready/valid handshake, so several requests to the same address are distinct accesses.

## Interface
- ADDR_WIDTH, 5: word address width; the full address is the tag.
- DATA_WIDTH, 8: data word width.
- LINES, 4: number of cache lines; power of two, ≥2. Age field width AW = clog2(LINES).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request strobe; accepted on an edge where req=1 and ready=1.
- address  in  ADDR_WIDTH  request address; sampled only at acceptance.
- data  in  DATA_WIDTH  write data; sampled only at acceptance.
- wren  in  1  1 = write, 0 = read; sampled only at acceptance.
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle completion pulse.
- hit  out  1  qualified by valid; 1 = request hit.
- q  out  DATA_WIDTH  read data, or written data for writes; holds its value between responses.
- mem_address  out  ADDR_WIDTH  backing RAM address.
- mem_data  out  DATA_WIDTH  backing RAM write data.
- mem_wren  out  1  backing RAM write enable.
- mem_q  in  DATA_WIDTH  backing RAM read data. The RAM registers its address, so read data is valid the cycle after the address is presented.

## Operation
- Per line: valid bit, dirty bit, tag[ADDR_WIDTH], data[DATA_WIDTH], age[AW].
- Age 0 = most recently used.
- Ages always form a permutation of 0..LINES-1.
- Reset:
  - all valid=0, dirty=0; age of line i = i.
  - state IDLE; q=0, valid=0, hit=0.
  - mem_address=0, mem_data=0, mem_wren=0.
- Lookup happens at acceptance: compare address against the tag of every valid line. At most one line matches.
- LRU touch of line k with age a:
  - every line (valid or not) with age < a increments;
  - line k gets age 0.
- Victim selection on a miss: lowest-index invalid line; otherwise the line with age LINES-1.
- States: IDLE, WB, FILL_REQ, FILL_WAIT, RESP.
  - IDLE, accept, hit:
    - write: line data = data, dirty = 1;
    - touch the line; capture q = line data (post-write);
    - go to RESP.
  - IDLE, accept, miss, victim valid and dirty: latch the victim and go to WB.
  - IDLE, accept, miss, otherwise:
    - read → FILL_REQ;
    - write → install, then RESP.
  - WB:
    - mem_address = victim tag, mem_data = victim data, mem_wren = 1, for exactly one cycle;
    - then read → FILL_REQ, write → install, then RESP.
  - FILL_REQ: mem_address = request address, mem_wren = 0; go to FILL_WAIT.
  - FILL_WAIT:
    - install the victim line with tag = address, data = mem_q, dirty = 0, valid = 1;
    - touch it; q = mem_q;
    - go to RESP.
  - Write install (no RAM read): tag = address, data = data, dirty = 1, valid = 1; touch it; q = data.
  - RESP: valid = 1, hit = registered hit flag; go to IDLE.
- Outside WB and FILL_REQ: mem_wren = 0, and mem_address / mem_data hold their last value.
- When ready = 0, req is ignored. There is no queueing.

## Timing
Latencies count from the acceptance edge (cycle 0) to the cycle in which valid is high:
- hit: 1;
- write miss, clean/invalid victim: 1;
- write miss, dirty victim: 2;
- read miss, clean/invalid victim: 3;
- read miss, dirty victim: 4.

Other timing rules:
- The earliest next acceptance is the cycle after RESP, so hits sustain 1 request per 2 cycles.
- The write-back always precedes the fill and never overlaps it. mem_wren is never high for two consecutive cycles.
- No RAM activity on a hit or on a write miss into a clean or invalid victim.
- Reset asserted in any state:
  - next cycle is IDLE with all lines invalid;
  - dirty data is discarded (no write-back);
  - valid = 0 and mem_wren = 0 from the cycle after the reset edge.
- The age counters are mod-LINES but never wrap, because the permutation invariant holds.

## Test plan
1. Reset; RAM[3]=0x5A; read 3:
   - FILL_REQ drives mem_address=3 with no mem_wren;
   - valid at cycle 3 with q=0x5A, hit=0.
   Read 3 again → valid at cycle 1, hit=1, q=0x5A, mem_wren never asserted.
2. Reset; write 0x11 to address 7 → valid at cycle 1, hit=0, no RAM writes. Read 7 → hit=1, q=0x11, RAM[7] unchanged.
3. Write 0xA1..0xA4 to addresses 1..4, read 1, then write 0xB5 to address 5:
   - victim is address 2;
   - one cycle of mem_wren=1 with mem_address=2, mem_data=0xA2;
   - valid at cycle 2.
4. From the state after scenario 3, read address 9 with RAM[9]=0x99:
   - victim is address 3; WB of 0xA3 to address 3, then a fill from address 9;
   - valid at cycle 4, q=0x99.
5. Hold req=1 continuously across a read miss → exactly one acceptance per RESP→IDLE return. Assert reset during FILL_WAIT of a read to 6:
   - next cycle ready=1, valid=0;
   - a previously dirty address now misses, and its RAM word keeps its old value.
6. LINES=8, ADDR_WIDTH=8: read 9 distinct addresses 0x10..0x18 → the ninth evicts 0x10. A re-read of 0x11 hits and a re-read of 0x10 misses.
